// File: rtl/cache_victim_writeback_pkg.sv
// Shared definitions for the victim writeback buffer.
//   - Default geometry (depth, line, beat and address widths)
//   - Derived constants: BEATS, BEATBYTES, OFFSETLEN
//   - wb_state_t: drain FSM encoding
//   - vwb_entry_t: one queued victim line at the default geometry
//   - line_offset_bits(): byte-offset width of a line, for parameterised users
package cache_victim_writeback_pkg;

  localparam int unsigned VWB_DEPTH   = 2;
  localparam int unsigned VWB_LINELEN = 512;
  localparam int unsigned VWB_BEATLEN = 64;
  localparam int unsigned VWB_PA_BITS = 56;

  localparam int unsigned BEATS     = VWB_LINELEN / VWB_BEATLEN;
  localparam int unsigned BEATBYTES = VWB_BEATLEN / 8;
  localparam int unsigned OFFSETLEN = $clog2(VWB_LINELEN / 8);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [VWB_PA_BITS-1:0] adr;
    logic [VWB_LINELEN-1:0] line;
  } vwb_entry_t;

  function automatic int unsigned line_offset_bits(input int unsigned linelen);
    return $clog2(linelen / 8);
  endfunction

endpackage

// File: rtl/vwb_entry_ram.sv
// Entry storage for the victim writeback buffer.
//   clk, reset          : clock, asynchronous active-high reset (clears all entries)
//   wr_en/wr_ptr/...    : write port; stores {valid=1, line-aligned adr, line} at wr_ptr
//   clr_en/clr_ptr      : invalidates the entry at clr_ptr (head pop)
//   rd_ptr/rd_adr/rd_line : read port at head
//   lookup_adr/match    : per-entry valid & line-address compare
//   lines               : all entry lines, present only with VICTIM_WB_FWD_EN
module vwb_entry_ram
  import cache_victim_writeback_pkg::*;
#(
  parameter  int unsigned DEPTH   = VWB_DEPTH,
  parameter  int unsigned LINELEN = VWB_LINELEN,
  parameter  int unsigned PA_BITS = VWB_PA_BITS,
  localparam int unsigned PTRW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [PTRW-1:0]    wr_ptr,
  input  logic [PA_BITS-1:0] wr_adr,
  input  logic [LINELEN-1:0] wr_line,
  input  logic               clr_en,
  input  logic [PTRW-1:0]    clr_ptr,
  input  logic [PTRW-1:0]    rd_ptr,
  output logic [PA_BITS-1:0] rd_adr,
  output logic [LINELEN-1:0] rd_line,
  input  logic [PA_BITS-1:0] lookup_adr,
  output logic [DEPTH-1:0]   match
`ifdef VICTIM_WB_FWD_EN
  ,
  output logic [DEPTH-1:0][LINELEN-1:0] lines
`endif
);

  localparam int unsigned OFFW = line_offset_bits(LINELEN);
  localparam logic [PA_BITS-1:0] ADR_MASK = {{(PA_BITS-OFFW){1'b1}}, {OFFW{1'b0}}};

  typedef struct packed {
    logic               valid;
    logic [PA_BITS-1:0] adr;
    logic [LINELEN-1:0] line;
  } entry_t;

  entry_t mem [DEPTH];

  // A push never targets the entry being popped (push is refused when full),
  // so clear and write cannot collide on one index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        mem[clr_ptr].valid <= 1'b0;
      end
      if (wr_en) begin
        mem[wr_ptr].valid <= 1'b1;
        mem[wr_ptr].adr   <= wr_adr & ADR_MASK;
        mem[wr_ptr].line  <= wr_line;
      end
    end
  end

  assign rd_adr  = mem[rd_ptr].adr;
  assign rd_line = mem[rd_ptr].line;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = mem[i].valid && (mem[i].adr == (lookup_adr & ADR_MASK));
    end
  end

`ifdef VICTIM_WB_FWD_EN
  always_comb begin
    lines = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lines[i] = mem[i].line;
    end
  end
`endif

endmodule

// File: rtl/cache_victim_writeback.sv
// Victim writeback buffer: queues dirty evicted lines and drains each one to
// the bus as BEATS beats under a per-beat req/ack handshake.
//   clk, reset                 : clock, asynchronous active-high reset
//   VictimValid/VictimReady    : eviction push handshake (VictimReady = ~full)
//   VictimAdr, VictimLine      : evicted line address (offset ignored) and data
//   LookupAdr/LookupHit        : combinational "line still pending writeback"
//   LookupData                 : youngest matching line (0 unless forwarding built)
//   BusReq/BusAdr/BusWData/BusLast/BusAck : beat write handshake
//   Drained                    : FIFO empty and drain FSM idle
// Optional feature macro: VICTIM_WB_FWD_EN builds the LookupData forwarding mux.
module cache_victim_writeback
  import cache_victim_writeback_pkg::*;
#(
  parameter int unsigned DEPTH   = VWB_DEPTH,
  parameter int unsigned LINELEN = VWB_LINELEN,
  parameter int unsigned BEATLEN = VWB_BEATLEN,
  parameter int unsigned PA_BITS = VWB_PA_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               VictimValid,
  output logic               VictimReady,
  input  logic [PA_BITS-1:0] VictimAdr,
  input  logic [LINELEN-1:0] VictimLine,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic [LINELEN-1:0] LookupData,
  output logic               BusReq,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATLEN-1:0] BusWData,
  output logic               BusLast,
  input  logic               BusAck,
  output logic               Drained
);

  localparam int unsigned NBEATS     = LINELEN / BEATLEN;
  localparam int unsigned NBEATBYTES = BEATLEN / 8;
  localparam int unsigned PTRW       = $clog2(DEPTH);
  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam int unsigned BW         = $clog2(NBEATS);

  wb_state_t          state, state_nx;
  logic [PTRW-1:0]    head, tail;
  logic [CW-1:0]      count;
  logic [BW-1:0]      beat, beat_nx;
  logic               full, empty, push, pop, last;
  logic [PA_BITS-1:0] rd_adr;
  logic [LINELEN-1:0] rd_line;
  logic [DEPTH-1:0]   match;
  logic [NBEATS-1:0][BEATLEN-1:0] rd_beats;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = VictimValid && !full;
  assign last  = (beat == BW'(NBEATS - 1));
  assign pop   = (state == BURST) && BusAck && last;

`ifdef VICTIM_WB_FWD_EN
  logic [DEPTH-1:0][LINELEN-1:0] ent_lines;
`endif

  vwb_entry_ram #(
    .DEPTH   (DEPTH),
    .LINELEN (LINELEN),
    .PA_BITS (PA_BITS)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (push),
    .wr_ptr     (tail),
    .wr_adr     (VictimAdr),
    .wr_line    (VictimLine),
    .clr_en     (pop),
    .clr_ptr    (head),
    .rd_ptr     (head),
    .rd_adr     (rd_adr),
    .rd_line    (rd_line),
    .lookup_adr (LookupAdr),
    .match      (match)
`ifdef VICTIM_WB_FWD_EN
    ,
    .lines      (ent_lines)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (push) tail <= tail + PTRW'(1);
      if (pop)  head <= head + PTRW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nx = BURST;
          beat_nx  = '0;
        end
      end
      BURST: begin
        if (BusAck) begin
          if (last) begin
            state_nx = IDLE;
            beat_nx  = '0;
          end else begin
            beat_nx = beat + BW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_beats    = rd_line;
  assign BusReq      = (state == BURST);
  assign BusLast     = (state == BURST) && last;
  assign BusAdr      = rd_adr + ((PA_BITS'(beat)) << $clog2(NBEATBYTES));
  assign BusWData    = rd_beats[beat];
  assign VictimReady = !full;
  assign Drained     = empty && (state == IDLE);
  assign LookupHit   = |match;

`ifdef VICTIM_WB_FWD_EN
  // Walk entries oldest to youngest (tail, tail+1, ..., tail-1) so the
  // youngest match overwrites older ones; stale slots never match.
  always_comb begin
    logic [PTRW-1:0] idx;
    idx        = '0;
    LookupData = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail + PTRW'(i);
      if (match[idx]) LookupData = ent_lines[idx];
    end
  end
`else
  assign LookupData = '0;
`endif

endmodule

// File: tb/tb_cache_victim_writeback.sv
module tb_cache_victim_writeback;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned LINELEN = 512;
  localparam int unsigned BEATLEN = 64;
  localparam int unsigned PA_BITS = 56;

  logic               clk;
  logic               reset;
  logic               VictimValid;
  logic               VictimReady;
  logic [PA_BITS-1:0] VictimAdr;
  logic [LINELEN-1:0] VictimLine;
  logic [PA_BITS-1:0] LookupAdr;
  logic               LookupHit;
  logic [LINELEN-1:0] LookupData;
  logic               BusReq;
  logic [PA_BITS-1:0] BusAdr;
  logic [BEATLEN-1:0] BusWData;
  logic               BusLast;
  logic               BusAck;
  logic               Drained;

  cache_victim_writeback #(
    .DEPTH   (DEPTH),
    .LINELEN (LINELEN),
    .BEATLEN (BEATLEN),
    .PA_BITS (PA_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .VictimValid (VictimValid),
    .VictimReady (VictimReady),
    .VictimAdr   (VictimAdr),
    .VictimLine  (VictimLine),
    .LookupAdr   (LookupAdr),
    .LookupHit   (LookupHit),
    .LookupData  (LookupData),
    .BusReq      (BusReq),
    .BusAdr      (BusAdr),
    .BusWData    (BusWData),
    .BusLast     (BusLast),
    .BusAck      (BusAck),
    .Drained     (Drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [PA_BITS-1:0] exp_adr  [8];
  logic [31:0]        exp_seed [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat b of a test line: upper word = seed, lower word = 0x11*(b+1).
  function automatic logic [63:0] beat_of(input logic [31:0] seed, input int b);
    return {seed, 32'(b + 1) * 32'h11};
  endfunction

  function automatic logic [511:0] mkline(input logic [31:0] seed);
    logic [511:0] l;
    l = '0;
    for (int b = 0; b < 8; b++) l[b*64 +: 64] = beat_of(seed, b);
    return l;
  endfunction

  task automatic push_line(input logic [PA_BITS-1:0] adr, input logic [31:0] seed);
    VictimValid = 1'b1;
    VictimAdr   = adr;
    VictimLine  = mkline(seed);
  endtask

  // Acks every beat and compares it against exp_adr/exp_seed in order.
  task automatic collect(input string tag, input int nlines, input int budget);
    int n;
    int l;
    int b;
    n = 0;
    BusAck = 1'b1;
    for (int c = 0; c < budget && n < nlines * 8; c++) begin
      if (BusReq === 1'b1) begin
        l = n / 8;
        b = n % 8;
        chk({tag, "_adr"},  BusAdr,   exp_adr[l] + PA_BITS'(b * 8));
        chk({tag, "_data"}, BusWData, beat_of(exp_seed[l], b));
        chk({tag, "_last"}, BusLast,  (b == 7));
        n++;
      end
      step();
    end
    chk({tag, "_beats"}, n, nlines * 8);
    BusAck = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    int pi;
    int l;
    int b;
    logic acc;

    reset       = 1'b1;
    VictimValid = 1'b0;
    VictimAdr   = '0;
    VictimLine  = '0;
    LookupAdr   = '0;
    BusAck      = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_busreq",  BusReq,      1'b0);
    chk("rst_buslast", BusLast,     1'b0);
    chk("rst_ready",   VictimReady, 1'b1);
    chk("rst_hit",     LookupHit,   1'b0);
    chk("rst_drained", Drained,     1'b1);
    reset = 1'b0;
    step();

    // Single line, ack held high
    BusAck = 1'b1;
    push_line(56'h8000_0040, 32'h0);
    step();
    VictimValid = 1'b0;
    chk("t1_idle_req", BusReq, 1'b0);
    chk("t1_drained0", Drained, 1'b0);
    exp_adr[0] = 56'h8000_0040; exp_seed[0] = 32'h0;
    collect("t1", 1, 30);
    chk("t1_drained1", Drained, 1'b1);
    chk("t1_req_off",  BusReq,  1'b0);

    // Fill then stall; third push ignored
    push_line(56'h1111_0000, 32'hA);
    step();
    chk("t2_ready1", VictimReady, 1'b1);
    push_line(56'h2222_0040, 32'hB);
    step();
    chk("t2_ready0", VictimReady, 1'b0);
    push_line(56'h3333_0080, 32'hC);
    step();
    VictimValid = 1'b0;
    chk("t2_ready_still0", VictimReady, 1'b0);
    chk("t2_req", BusReq, 1'b1);
    exp_adr[0] = 56'h1111_0000; exp_seed[0] = 32'hA;
    exp_adr[1] = 56'h2222_0040; exp_seed[1] = 32'hB;
    collect("t2", 2, 60);
    chk("t2_drained", Drained, 1'b1);
    seen = 0;
    repeat (4) begin
      step();
      if (BusReq !== 1'b0) seen++;
    end
    chk("t2_no_third", seen, 0);

    // Full, push offered on last-beat pop is refused
    push_line(56'h3000_0000, 32'hD);
    step();
    push_line(56'h3000_0080, 32'hE);
    step();
    VictimValid = 1'b0;
    BusAck = 1'b1;
    repeat (7) step();
    chk("t3_last",     BusLast, 1'b1);
    chk("t3_last_adr", BusAdr,  56'h3000_0038);
    push_line(56'h3000_0100, 32'hF);
    chk("t3_ready_full", VictimReady, 1'b0);
    step();
    BusAck = 1'b0;
    chk("t3_ready_after_pop", VictimReady, 1'b1);
    chk("t3_idle_gap", BusReq, 1'b0);
    step();
    VictimValid = 1'b0;
    chk("t3_ready_refull", VictimReady, 1'b0);
    exp_adr[0] = 56'h3000_0080; exp_seed[0] = 32'hE;
    exp_adr[1] = 56'h3000_0100; exp_seed[1] = 32'hF;
    collect("t3", 2, 60);
    chk("t3_drained", Drained, 1'b1);

    // Lookup
    push_line(56'h1000, 32'h1);
    step();
    push_line(56'h2040, 32'h2);
    step();
    VictimValid = 1'b0;
    LookupAdr = 56'h2058;
    #1;
    chk("t4_hit_2058", LookupHit, 1'b1);
`ifdef VICTIM_WB_FWD_EN
    chk("t4_data_2058", LookupData, mkline(32'h2));
`else
    chk("t4_data_2058", LookupData, 512'h0);
`endif
    LookupAdr = 56'h3000;
    #1;
    chk("t4_hit_3000",  LookupHit,  1'b0);
    chk("t4_data_3000", LookupData, 512'h0);
    LookupAdr = 56'h1000;
    #1;
    chk("t4_hit_1000", LookupHit, 1'b1);
`ifdef VICTIM_WB_FWD_EN
    chk("t4_data_1000", LookupData, mkline(32'h1));
`endif
    BusAck = 1'b1;
    repeat (7) step();
    chk("t4_last",           BusLast,   1'b1);
    chk("t4_hit_before_ack", LookupHit, 1'b1);
    step();
    BusAck = 1'b0;
    chk("t4_hit_after_ack", LookupHit, 1'b0);
    chk("t4_gap", BusReq, 1'b0);
    exp_adr[0] = 56'h2040; exp_seed[0] = 32'h2;
    collect("t4", 1, 30);
    chk("t4_drained", Drained, 1'b1);

    // Reset mid-burst at beat 3
    push_line(56'h5000_0000, 32'h5);
    step();
    VictimValid = 1'b0;
    BusAck = 1'b1;
    step();
    repeat (3) step();
    chk("t5_beat3_adr", BusAdr, 56'h5000_0018);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_req_async",     BusReq,      1'b0);
    chk("t5_drained_async", Drained,     1'b1);
    chk("t5_ready_async",   VictimReady, 1'b1);
    step();
    step();
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (BusReq !== 1'b0) seen++;
    end
    chk("t5_quiet", seen, 0);
    chk("t5_drained", Drained, 1'b1);
    BusAck = 1'b0;

    // Wrap: 5 lines, pushes offered whenever ready, acks always high.
    // Offsets in the pushed address must be dropped.
    for (int k = 0; k < 5; k++) begin
      exp_adr[k]  = 56'h6000_0000 + PA_BITS'(k * 32'h1040);
      exp_seed[k] = 32'h60 + 32'(k);
    end
    BusAck = 1'b1;
    pi = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 40; c++) begin
      if (pi < 5) push_line(exp_adr[pi] + PA_BITS'(pi + 3), exp_seed[pi]);
      else VictimValid = 1'b0;
      acc = (pi < 5) && (VictimReady === 1'b1);
      if (BusReq === 1'b1) begin
        l = n / 8;
        b = n % 8;
        chk("t6_adr",  BusAdr,   exp_adr[l] + PA_BITS'(b * 8));
        chk("t6_data", BusWData, beat_of(exp_seed[l], b));
        chk("t6_last", BusLast,  (b == 7));
        n++;
      end
      step();
      if (acc) pi++;
    end
    VictimValid = 1'b0;
    BusAck = 1'b0;
    chk("t6_beats",   n,  40);
    chk("t6_pushes",  pi, 5);
    chk("t6_drained", Drained, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_victim_writeback.md
Name: cache_victim_writeback

Overview:
- Receives dirty lines evicted by the cache replacement logic and queues them in a small FIFO.
- Drains each queued line to the bus as a burst of fixed-width beats under a per-beat req/ack handshake.
- Sits between the cache controller FSM (eviction side) and the bus interface.
- Exposes a combinational address-match so the cache stalls a refill of a line still pending writeback.

Parameters:
- DEPTH, 2, number of line entries (power of 2, >=2).
- LINELEN, 512, line width in bits.
- BEATLEN, 64, bus data width in bits; LINELEN/BEATLEN = BEATS (power of 2, >=2).
- PA_BITS, 56, physical address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- VictimValid  in  1  eviction side presents a line.
- VictimReady  out  1  buffer can accept; equals ~Full.
- VictimAdr  in  PA_BITS  line-aligned address; low log2(LINELEN/8) bits ignored and stored as 0.
- VictimLine  in  LINELEN  line data; beat 0 = bits [BEATLEN-1:0].
- LookupAdr  in  PA_BITS  address of pending cache miss.
- LookupHit  out  1  some valid entry holds LookupAdr's line.
- LookupData  out  LINELEN  forwarded line (see Optional Feature).
- BusReq  out  1  beat write request.
- BusAdr  out  PA_BITS  beat address.
- BusWData  out  BEATLEN  beat data.
- BusLast  out  1  final beat of the line.
- BusAck  in  1  beat accepted.
- Drained  out  1  FIFO empty and FSM IDLE; used for flush completion.

Behaviour:
- Reset (async assert, clears at next edge after deassert): count=0, head=tail=0, beat=0, FSM=IDLE, all entry valid bits 0.
- Reset outputs: BusReq=0, BusLast=0, VictimReady=1, LookupHit=0, Drained=1.
- Push: on VictimValid & VictimReady, capture {address, line} at tail; tail++ (mod DEPTH); entry valid in the same edge.
- Back-to-back pushes allowed every cycle.
- Full: VictimReady=0. A push while full is ignored, even in the cycle a pop occurs. There is no same-cycle pass-through.
- FSM IDLE: if count>0, go to BURST next cycle with beat=0. Otherwise stay.
- FSM BURST:
  - BusReq=1. BusAdr = head.adr + beat*(BEATLEN/8). BusWData = head.line slice [beat]. BusLast = (beat==BEATS-1).
  - Bus outputs hold stable until BusAck.
  - On BusAck with not last: beat++.
  - On BusAck with last: pop head (valid=0, head++, count--), beat=0, go to IDLE.
  - Minimum one idle cycle between lines. Line latency is BEATS acks plus 1 cycle.
- Simultaneous push and final-beat pop: count unchanged, both pointers advance.
- LookupHit: combinational OR over valid entries of (entry.adr line bits == LookupAdr line bits). An entry being drained stays hittable until its last ack edge.
- Duplicate addresses may be queued. Order is strictly FIFO.
- Pointer wrap: head and tail are log2(DEPTH) bits plus a separate count. Full = (count==DEPTH); Empty = (count==0).
- BusAck while BusReq=0 is ignored.
- Reset mid-burst drops all entries; BusReq falls asynchronously.
- Drained = Empty & IDLE.

Optional Feature:
- Macro: VICTIM_WB_FWD_EN.
- Defined: LookupData = line of the youngest matching valid entry (priority from tail-1 backward). Undefined when LookupHit=0; drive 0.
- Not defined: LookupData tied 0 and no match-data mux is built. LookupHit is still produced; the cache must stall until the hit clears.

Decomposition:
- Shared cache package: BEATS, BEATBYTES, OFFSETLEN (= log2(LINELEN/8)), and a wb_state_t enum {IDLE, BURST}.
- Also in the package: a vwb_entry_t struct {valid, adr, line}.
- One sub-module, vwb_entry_ram: the DEPTH-entry storage. It has a write port at tail, a read port at head, and a parallel address-compare vector output.
- Top level holds the pointers, count, FSM, beat counter and forwarding mux.

Test Plan:
- Single line: push adr 0x8000_0040 with 8 beats of data 0x11..0x88, BusAck held 1.
  - Beats appear at 0x..40, 0x..48 … 0x..78 with data in order.
  - BusLast only on 0x..78; Drained=1 one cycle after the last ack.
- Fill then stall: with BusAck=0, push 2 lines. VictimReady drops to 0 after the second push; a third push is ignored.
  - Then ack all 16 beats. Exactly 2 lines emerge, FIFO order preserved.
- Full with push on last-beat pop: offered push is rejected (VictimReady=0).
  - Next cycle VictimReady=1 and the push is accepted; count returns to 2.
- Lookup: queue 0x1000 and 0x2040.
  - LookupAdr 0x2058 → LookupHit=1; 0x3000 → 0.
  - Drain 0x1000; 0x1000 stays a hit until its last-ack edge, then 0.
  - With VICTIM_WB_FWD_EN, LookupData equals the 0x2040 line.
- Reset mid-burst at beat 3: BusReq falls immediately; Drained=1.
  - After release, no further bus traffic until a new push.
- Wrap: push and drain 5 lines in sequence (DEPTH=2). Addresses and data are correct across pointer wrap; count never exceeds 2.
